// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned NREG_DEF  = 8;
    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned IDX_W     = 3;

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer flips only on contended grants.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic contended
);

    // 0: requester a wins a tie, 1: requester b wins a tie
    logic ptr_b;

    assign contended = en & req_a & req_b;
    assign gnt_a     = en & req_a & (~req_b | ~ptr_b);
    assign gnt_b     = en & req_b & (~req_a | ptr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_b <= 1'b0;
        end else if (contended) begin
            ptr_b <= ~ptr_b;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates CPU and debug writes into the register file, with an optional
// post-reset clear sequence enabled by REGFILE_CLEAR_SEQ_EN.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             cpu_req,
    input  logic [IDX_W-1:0] cpu_dr,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             cpu_gnt,
    input  logic             dbg_req,
    input  logic [IDX_W-1:0] dbg_dr,
    input  logic [WIDTH-1:0] dbg_data,
    output logic             dbg_gnt,
    output logic             rf_ld,
    output logic [IDX_W-1:0] rf_dr,
    output logic [WIDTH-1:0] rf_bus,
    output logic             busy,
    output logic [CNT_W-1:0] coll_cnt
);

`ifdef REGFILE_CLEAR_SEQ_EN
    localparam state_e RESET_STATE = CLEAR;
`else
    localparam state_e RESET_STATE = ARB;
`endif
    localparam reg_idx_t         LAST_IDX = IDX_W'(NREG - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state;
    state_e           state_d;
    reg_idx_t         clr_idx;
    reg_idx_t         clr_idx_d;
    logic             ld_d;
    reg_idx_t         dr_d;
    logic [WIDTH-1:0] bus_d;
    logic [CNT_W-1:0] cnt_d;
    logic             arb_en;
    logic             contended;

    assign arb_en = (state == ARB);

    rr_arb2 u_arb (
        .clk       (Clk),
        .rst_n     (Reset),
        .en        (arb_en),
        .req_a     (cpu_req),
        .req_b     (dbg_req),
        .gnt_a     (cpu_gnt),
        .gnt_b     (dbg_gnt),
        .contended (contended)
    );

`ifdef REGFILE_CLEAR_SEQ_EN
    assign busy = (state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= RESET_STATE;
            clr_idx  <= '0;
            rf_ld    <= 1'b0;
            rf_dr    <= '0;
            rf_bus   <= '0;
            coll_cnt <= '0;
        end else begin
            state    <= state_d;
            clr_idx  <= clr_idx_d;
            rf_ld    <= ld_d;
            rf_dr    <= dr_d;
            rf_bus   <= bus_d;
            coll_cnt <= cnt_d;
        end
    end

    // Next state, register-file write and collision count; rf_dr/rf_bus hold when idle.
    always_comb begin
        state_d   = state;
        clr_idx_d = clr_idx;
        ld_d      = 1'b0;
        dr_d      = rf_dr;
        bus_d     = rf_bus;
        cnt_d     = coll_cnt;
        unique case (state)
            CLEAR: begin
                ld_d      = 1'b1;
                dr_d      = clr_idx;
                bus_d     = '0;
                clr_idx_d = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (cpu_gnt) begin
                    ld_d  = 1'b1;
                    dr_d  = cpu_dr;
                    bus_d = cpu_data;
                end else if (dbg_gnt) begin
                    ld_d  = 1'b1;
                    dr_d  = dbg_dr;
                    bus_d = dbg_data;
                end
                if (contended && (coll_cnt != CNT_MAX)) begin
                    cnt_d = coll_cnt + 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: expected writes are queued by the stimulus
// and popped by a monitor whenever rf_ld is presented.
`timescale 1ns/1ps
module tb_regfile_arbiter;

    typedef struct {
        logic [2:0]  dr;
        logic [15:0] data;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req;
    logic [2:0]  cpu_dr;
    logic [15:0] cpu_data;
    logic        cpu_gnt;
    logic        dbg_req;
    logic [2:0]  dbg_dr;
    logic [15:0] dbg_data;
    logic        dbg_gnt;
    logic        rf_ld;
    logic [2:0]  rf_dr;
    logic [15:0] rf_bus;
    logic        busy;
    logic [7:0]  coll_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic m_ptr  = 1'b0;
    int   m_cnt  = 0;

    regfile_arbiter #(.NREG(8), .WIDTH(16), .CNT_W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .cpu_req  (cpu_req),
        .cpu_dr   (cpu_dr),
        .cpu_data (cpu_data),
        .cpu_gnt  (cpu_gnt),
        .dbg_req  (dbg_req),
        .dbg_dr   (dbg_dr),
        .dbg_data (dbg_data),
        .dbg_gnt  (dbg_gnt),
        .rf_ld    (rf_ld),
        .rf_dr    (rf_dr),
        .rf_bus   (rf_bus),
        .busy     (busy),
        .coll_cnt (coll_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_wr(input logic [2:0] dr, input logic [15:0] data);
        exp_t e;
        e.dr   = dr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic run_clear();
        for (int i = 0; i < 8; i++) begin
            check("clear_busy", 32'(busy), 32'd1);
            check("clear_gnt", {cpu_gnt, dbg_gnt}, 2'b00);
            expect_wr(3'(i), 16'h0000);
            tick();
        end
        check("clear_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic dbg_first_cycle();
        dbg_req  = 1'b1;
        dbg_dr   = 3'd5;
        dbg_data = 16'hA5A5;
        #1;
        check("first_dbg_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
        check("first_busy", 32'(busy), 32'd0);
        expect_wr(3'd5, 16'hA5A5);
        tick();
        dbg_req = 1'b0;
    endtask

    task automatic contend(input logic [15:0] cdat, input logic [15:0] ddat);
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
        cpu_dr   = 3'd1;
        dbg_dr   = 3'd2;
        cpu_data = cdat;
        dbg_data = ddat;
        #1;
        if (!m_ptr) begin
            check("contend_gnt_cpu", {cpu_gnt, dbg_gnt}, 2'b10);
            expect_wr(3'd1, cdat);
        end else begin
            check("contend_gnt_dbg", {cpu_gnt, dbg_gnt}, 2'b01);
            expect_wr(3'd2, ddat);
        end
        m_ptr = ~m_ptr;
        if (m_cnt != 255) m_cnt++;
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_rf_ld", 32'(rf_ld), 32'd0);
        check("rst_rf_dr", 32'(rf_dr), 32'd0);
        check("rst_rf_bus", 32'(rf_bus), 32'd0);
        check("rst_coll_cnt", 32'(coll_cnt), 32'd0);
`ifdef REGFILE_CLEAR_SEQ_EN
        check("rst_busy", 32'(busy), 32'd1);
`else
        check("rst_busy", 32'(busy), 32'd0);
`endif
    endtask

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            checks++;
            if (cpu_gnt && dbg_gnt) begin
                errors++;
                $display("FAIL gnt_mutex actual=11 expected=at most one t=%0t", $time);
            end
            if (rf_ld === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual dr=%0d bus=%0h expected=no write t=%0t",
                             rf_dr, rf_bus, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rf_dr !== e.dr || rf_bus !== e.data) begin
                        errors++;
                        $display("FAIL write actual dr=%0d bus=%0h expected dr=%0d bus=%0h t=%0t",
                                 rf_dr, rf_bus, e.dr, e.data, $time);
                    end
                end
            end
        end
    end

    initial begin
        Reset    = 1'b0;
        cpu_req  = 1'b0;
        cpu_dr   = 3'd0;
        cpu_data = 16'h0;
        dbg_req  = 1'b0;
        dbg_dr   = 3'd0;
        dbg_data = 16'h0;
        #1;
        check_reset_outputs();
        check("rst_gnt", {cpu_gnt, dbg_gnt}, 2'b00);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

`ifdef REGFILE_CLEAR_SEQ_EN
        run_clear();
`else
        dbg_first_cycle();
`endif

        // CPU alone: granted same cycle, written next edge, then held while idle
        cpu_req  = 1'b1;
        cpu_dr   = 3'd3;
        cpu_data = 16'hBEEF;
        #1;
        check("cpu_alone_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
        expect_wr(3'd3, 16'hBEEF);
        tick();
        cpu_req = 1'b0;
        tick();
        check("idle_rf_ld", 32'(rf_ld), 32'd0);
        check("hold_rf_dr", 32'(rf_dr), 32'd3);
        check("hold_rf_bus", 32'(rf_bus), 32'hBEEF);
        check("no_coll", 32'(coll_cnt), 32'd0);

        // Debug alone, pointer unaffected
        dbg_req  = 1'b1;
        dbg_dr   = 3'd6;
        dbg_data = 16'h0606;
        #1;
        check("dbg_alone_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
        expect_wr(3'd6, 16'h0606);
        tick();
        dbg_req = 1'b0;

        // Four contended cycles alternate CPU, DBG, CPU, DBG
        for (int i = 0; i < 4; i++) contend(16'h1111, 16'h2222);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("coll_cnt_4", 32'(coll_cnt), 32'(m_cnt));

        // An uncontended grant between contended ones leaves the pointer alone
        contend(16'h3333, 16'h4444);
        dbg_req  = 1'b0;
        cpu_dr   = 3'd4;
        cpu_data = 16'h4444;
        #1;
        check("uncontended_cpu_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
        expect_wr(3'd4, 16'h4444);
        tick();
        contend(16'h5555, 16'h6666);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("coll_cnt_6", 32'(coll_cnt), 32'd6);

        // Saturation
        for (int i = 0; i < 300; i++) contend(16'(i), ~16'(i));
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("coll_cnt_sat", 32'(coll_cnt), 32'd255);

        // Reset in the middle of an operation aborts it immediately
`ifdef REGFILE_CLEAR_SEQ_EN
        @(negedge Clk);
        #1 Reset = 1'b0;
        #1;
        m_ptr = 1'b0;
        m_cnt = 0;
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_wr(3'(i), 16'h0000);
            tick();
        end
        @(negedge Clk);
        #1 Reset = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge Clk);
        Reset = 1'b1;
        run_clear();
`else
        cpu_req  = 1'b1;
        cpu_dr   = 3'd7;
        cpu_data = 16'h7777;
        #1;
        expect_wr(3'd7, 16'h7777);
        tick();
        cpu_req = 1'b0;
        @(negedge Clk);
        #1 Reset = 1'b0;
        #1;
        check_reset_outputs();
        m_ptr = 1'b0;
        m_cnt = 0;
        @(negedge Clk);
        Reset = 1'b1;
        dbg_first_cycle();
`endif

        // Pointer and counter restart from reset values
        contend(16'hAAAA, 16'hBBBB);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("post_rst_coll", 32'(coll_cnt), 32'd1);
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameters SHALL be declared one per line as: NREG, 8, number of registers in the register file. WIDTH, 16, register and bus width. CNT_W, 8, width of the collision counter.
REQ-002 Clk  input  1  system clock, all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous active-low reset; the block SHALL be in reset while Reset=0.
REQ-004 cpu_req  input  1  CPU writeback write request.
REQ-005 cpu_dr  input  3  CPU destination register index.
REQ-006 cpu_data  input  WIDTH  CPU write data.
REQ-007 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-008 dbg_req  input  1  debug/loader write request.
REQ-009 dbg_dr  input  3  debug destination register index.
REQ-010 dbg_data  input  WIDTH  debug write data.
REQ-011 dbg_gnt  output  1  debug request accepted this cycle.
REQ-012 rf_ld  output  1  register-file load enable (drives LD_REG).
REQ-013 rf_dr  output  3  register-file destination select.
REQ-014 rf_bus  output  WIDTH  register-file write data.
REQ-015 busy  output  1  high while the clear sequence runs.
REQ-016 coll_cnt  output  CNT_W  saturating count of cycles with both requests granted-contended.

Function
- REQ-017 The FSM SHALL have two states, CLEAR and ARB; CLEAR SHALL move to ARB after index NREG-1 is written.
- REQ-018 In CLEAR the block SHALL write 0 to one register per cycle, index 0..NREG-1 ascending, with rf_ld=1 for NREG consecutive cycles.
- REQ-019 In CLEAR, busy SHALL be 1 and both gnt outputs SHALL be 0.
- REQ-020 In ARB, busy SHALL be 0; cpu_gnt and dbg_gnt SHALL be combinational from the current requests and priority pointer, and at most one SHALL be high in any cycle.
- REQ-021 With a single request, that request SHALL be granted in the same cycle.
- REQ-022 With both requests, the side selected by the priority pointer SHALL be granted. After reset the pointer SHALL select CPU.
- REQ-023 The pointer SHALL flip to the other side after every contended grant, giving round-robin; uncontended grants SHALL NOT change the pointer.
- REQ-024 A granted request SHALL produce rf_ld=1, with rf_dr and rf_bus equal to the granted index and data, registered on the next rising edge; latency is 1 cycle from grant to load.
- REQ-025 rf_ld SHALL be 0 in every cycle not following a grant or CLEAR step, and rf_dr/rf_bus SHALL hold their last values.
- REQ-026 A requester holding req high SHALL receive one grant per cycle it wins; each grant is one write.
- REQ-027 coll_cnt SHALL increment by 1 on each contended cycle in ARB and saturate at 2^CNT_W-1 without wrap.

Reset
- REQ-028 Reset assertion SHALL force the following immediately, regardless of Clk: state=CLEAR, clear index=0, rf_ld=0, rf_dr=0, rf_bus=0, pointer=CPU, coll_cnt=0.
- REQ-029 Reset asserted mid-CLEAR or mid-write SHALL abort that operation, and the full clear sequence SHALL restart from index 0 after deassertion.
- REQ-030 After Reset deassertion, the first rising edge SHALL perform the index-0 clear write.

Configuration
- REQ-031 With REGFILE_CLEAR_SEQ_EN defined, the CLEAR state and busy behaviour SHALL be as above.
- REQ-032 Without REGFILE_CLEAR_SEQ_EN, reset SHALL enter ARB directly, busy SHALL be constant 0, and no clear writes SHALL be issued.

Structure
- REQ-033 Package regfile_pkg SHALL hold the state enum (CLEAR, ARB), the NREG/WIDTH defaults and the register index typedef.
- REQ-034 A sub-module rr_arb2 (2-way round-robin arbiter with pointer) is natural; the FSM, datapath registers and counter SHALL stay in regfile_arbiter.

Verification
- REQ-035 Reset release with clear enabled -> rf_ld=1 for 8 cycles with rf_dr 0..7 and rf_bus=0x0000, busy=1 throughout, then busy=0.
- REQ-036 cpu_req=1, cpu_dr=3, cpu_data=0xBEEF alone in ARB -> cpu_gnt=1 the same cycle; next cycle rf_ld=1, rf_dr=3, rf_bus=0xBEEF.
- REQ-037 Both requests held 4 cycles (cpu R1=0x1111, dbg R2=0x2222) -> grants CPU, DBG, CPU, DBG; coll_cnt=4.
- REQ-038 Reset pulsed low during the clear step at index 4 -> outputs zero immediately; after release the clear restarts at index 0.
- REQ-039 300 contended cycles with CNT_W=8 -> coll_cnt saturates at 255.
- REQ-040 Build without REGFILE_CLEAR_SEQ_EN; dbg_req on the first cycle after reset -> dbg_gnt=1 immediately, busy stays 0.
